// File: rtl/stepgen_velramp.sv
//-----------------------------------------------------------------------------
// stepgen_velramp
//   Velocity ramp feeder for the step generator. Latches a host-commanded
//   signed velocity on cmd_load and slews the applied velocity toward it by
//   'accel' on every prescaled update tick. A watchdog forces a ramp to zero
//   when the host stops refreshing commands.
//
//   Optional build macro: STEPGEN_VELRAMP_ZERO_DWELL_EN
//     When defined, a slew step that would cross zero lands on exactly 0 and
//     velocity then holds there for ZD ticks (DWELL) before continuing.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   cmd_vel    [F:0]    commanded velocity, two's complement
//   cmd_load            single-cycle strobe, captures cmd_vel into target
//   accel      [A-1:0]  unsigned velocity step per tick (0 = jump to target)
//   rate_div   [D-1:0]  tick period is rate_div+1 clocks
//   wdt_limit  [WD-1:0] watchdog timeout in clocks (0 = disabled)
//   velocity   [F:0]    applied velocity to the step generator
//   at_target           velocity equals target
//   wdt_trip            sticky watchdog-expired flag
//-----------------------------------------------------------------------------
module stepgen_velramp #(
   parameter int F  = 10,
   parameter int A  = 6,
   parameter int D  = 8,
   parameter int WD = 16,
   parameter int ZD = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [F:0]    cmd_vel,
   input  logic          cmd_load,
   input  logic [A-1:0]  accel,
   input  logic [D-1:0]  rate_div,
   input  logic [WD-1:0] wdt_limit,
   output logic [F:0]    velocity,
   output logic          at_target,
   output logic          wdt_trip
);

   typedef enum logic [1:0] {
      TRACK,
      RAMP,
      TRIP,
      DWELL
   } state_t;

   state_t state, state_n;

   logic [F:0]    target, target_n;
   logic [F:0]    vel_n;
   logic [D-1:0]  presc, presc_n;
   logic [WD-1:0] wdt_cnt, wdt_cnt_n;
   logic          wdt_trip_n;
   logic          tick;
   logic          expire;

   // Slew datapath
   logic signed [F+1:0] vel_x, tgt_x, diff, mag, acc_x;
   logic [F:0]          acc_w, step_w, slew_res;

`ifdef STEPGEN_VELRAMP_ZERO_DWELL_EN
   localparam int ZW = (ZD > 1) ? $clog2(ZD) : 1;
   logic [ZW-1:0] dwell_cnt, dwell_cnt_n;
   logic          crossing;
`else
   logic          unused_zd;
   assign unused_zd = (ZD == 0);
`endif

   assign at_target = (velocity == target);

   assign acc_x = signed'({{(F+2-A){1'b0}}, accel});
   assign acc_w = {{(F+1-A){1'b0}}, accel};

   always_comb begin
      vel_x = {velocity[F], velocity};
      tgt_x = {target[F], target};
      diff  = tgt_x - vel_x;
      mag   = diff[F+1] ? -diff : diff;
      // A partial step never overshoots, so the wide sum always fits in F+1
      // bits; its low bits are therefore computed directly at F+1 width.
      step_w = diff[F+1] ? (velocity - acc_w) : (velocity + acc_w);
      if ((accel == '0) || (mag <= acc_x)) begin
         slew_res = target;
      end else begin
         slew_res = step_w;
      end
   end

`ifdef STEPGEN_VELRAMP_ZERO_DWELL_EN
   assign crossing = (velocity != '0) && (slew_res != '0) &&
                     (velocity[F] != slew_res[F]);
`endif

   always_comb begin
      // Update-rate prescaler
      tick    = (presc == '0);
      presc_n = tick ? rate_div : presc - D'(1);

      // Watchdog: saturating counter, expiry fires once on reaching the limit
      expire    = 1'b0;
      wdt_cnt_n = wdt_cnt;
      if (cmd_load) begin
         wdt_cnt_n = '0;
      end else begin
         wdt_cnt_n = (wdt_cnt >= wdt_limit) ? wdt_limit : wdt_cnt + WD'(1);
         expire    = (wdt_limit != '0) && (wdt_cnt_n == wdt_limit) && !wdt_trip;
      end

      // Target and trip flag; a load on the expiry cycle wins
      target_n   = target;
      wdt_trip_n = wdt_trip;
      if (cmd_load) begin
         target_n   = cmd_vel;
         wdt_trip_n = 1'b0;
      end else if (expire) begin
         target_n   = '0;
         wdt_trip_n = 1'b1;
      end

      vel_n   = velocity;
      state_n = state;

`ifdef STEPGEN_VELRAMP_ZERO_DWELL_EN
      dwell_cnt_n = dwell_cnt;
      if (state == DWELL) begin
         // Velocity is pinned at 0 while dwelling
         if (cmd_load && (cmd_vel == '0)) begin
            state_n = TRACK;
         end else if (tick) begin
            if (dwell_cnt == ZW'(ZD - 1)) begin
               state_n = wdt_trip_n ? TRIP :
                         ((velocity == target_n) ? TRACK : RAMP);
            end else begin
               dwell_cnt_n = dwell_cnt + ZW'(1);
            end
         end
      end else if (tick && crossing) begin
         vel_n       = '0;
         state_n     = DWELL;
         dwell_cnt_n = '0;
      end else begin
         if (tick) begin
            vel_n = slew_res;
         end
         state_n = wdt_trip_n ? TRIP : ((vel_n == target_n) ? TRACK : RAMP);
      end
`else
      if (tick) begin
         vel_n = slew_res;
      end
      state_n = wdt_trip_n ? TRIP : ((vel_n == target_n) ? TRACK : RAMP);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         velocity  <= '0;
         target    <= '0;
         presc     <= '0;
         wdt_cnt   <= '0;
         wdt_trip  <= 1'b0;
         state     <= TRACK;
`ifdef STEPGEN_VELRAMP_ZERO_DWELL_EN
         dwell_cnt <= '0;
`endif
      end else begin
         velocity  <= vel_n;
         target    <= target_n;
         presc     <= presc_n;
         wdt_cnt   <= wdt_cnt_n;
         wdt_trip  <= wdt_trip_n;
         state     <= state_n;
`ifdef STEPGEN_VELRAMP_ZERO_DWELL_EN
         dwell_cnt <= dwell_cnt_n;
`endif
      end
   end

endmodule

// File: doc/stepgen_velramp.md
Name: stepgen_velramp

Overview:
- Upstream feeder for the step generator's signed velocity input.
- Latches the host-commanded velocity on a load strobe, then slews the applied velocity toward it by a programmable step on each prescaled update tick.
- Watchdog forces a ramp to zero if the host stops refreshing commands.
- Output drives the step generator's velocity port directly: same F+1-bit two's-complement format.

Parameters:
- F, 10: fractional width; velocity ports are F+1 bits two's complement (bit F = sign).
- A, 6: width of accel step magnitude.
- D, 8: width of update-rate prescaler.
- WD, 16: width of watchdog limit/counter.
- ZD, 4: zero-dwell tick count (used only with optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_vel  in  F+1  commanded velocity, two's complement.
- cmd_load  in  1  single-cycle strobe; captures cmd_vel into target.
- accel  in  A  unsigned velocity change per tick; 0 = jump directly to target.
- rate_div  in  D  tick period = rate_div+1 clocks.
- wdt_limit  in  WD  watchdog timeout in clocks; 0 = watchdog disabled.
- velocity  out  F+1  applied velocity to step generator.
- at_target  out  1  high when velocity == target.
- wdt_trip  out  1  sticky watchdog-expired flag.

Behaviour:
- Reset (async, rst_n low): all outputs and registers clear.
  - velocity=0, target=0, at_target=1, wdt_trip=0.
  - Prescaler=0, watchdog count=0, state=TRACK.
- Reset asserted mid-ramp: velocity drops to 0 immediately, with no ramping.
- Load: on cmd_load, target <= cmd_vel at that edge. New target is visible to the slew logic on the next cycle.
- Prescaler: counts down from rate_div. tick=1 when count==0, then reloads rate_div.
  - rate_div=0 gives a tick every clock.
  - A rate_div change takes effect at the next reload.
- Slew on tick, states TRACK/RAMP:
  - diff = target - velocity, computed sign-extended to F+2 bits (no overflow).
  - accel==0 or |diff| <= accel: velocity <= target.
  - Otherwise: velocity <= velocity ± accel, sign of diff, computed in F+2 bits.
  - Never overshoots, so the result always fits in F+1 bits.
  - Most-negative target (-2^F) is reached exactly.
- Latency: velocity updates only on tick edges. Outside ticks velocity holds.
- State TRACK: velocity == target. Go to RAMP on the cycle target differs.
- State RAMP: slewing. Go to TRACK when the update lands on target.
- at_target: combinational compare of velocity and target.
- Watchdog:
  - Counter clears on cmd_load; otherwise increments, saturating at wdt_limit.
  - When count reaches a nonzero wdt_limit: wdt_trip <= 1, target <= 0, state TRIP.
- State TRIP: slew toward 0 at the normal accel/tick rate.
  - cmd_load clears wdt_trip, loads target, and returns to RAMP or TRACK.
- Simultaneous cmd_load and expiry in the same cycle: load wins; wdt_trip stays 0; counter clears.
- wdt_limit changed to 0 while tripped: trip stays set until the next cmd_load.
- cmd_load while ramping: the new target applies from the next tick. There is no restart of the prescaler.

Optional Feature:
- Macro: STEPGEN_VELRAMP_ZERO_DWELL_EN.
- Defined:
  - A slew update that would cross zero (old and new sign differ, both nonzero) instead lands on exactly 0.
  - Velocity then holds at 0 for ZD ticks (state DWELL) before continuing toward target.
  - This gives the step generator's direction setup time a clean zero window.
  - A cmd_load to target 0 during DWELL ends DWELL into TRACK.
  - Watchdog trip during DWELL keeps dwelling, then moves to TRIP.
- Undefined: zero crossings pass straight through per the normal slew rule. DWELL state and ZD are unused.

Test Plan:
- Reset, then cmd_load cmd_vel=100, accel=30, rate_div=3:
  - velocity=30,60,90,100 at ticks 4 clocks apart.
  - at_target rises with 100; state returns to TRACK.
- accel=0, cmd_load cmd_vel=-1024 from velocity 0: velocity=-1024 (0x400) on the next tick; no overflow.
- velocity=50, cmd_load -50, accel=40, rate_div=0:
  - Macro undefined: 10, -30, -50.
  - Macro defined, ZD=2: 10, 0, 0, 0, -40, -50.
- wdt_limit=20, target=200 reached, no further loads:
  - wdt_trip=1 on clock 20 after the last load; velocity ramps to 0.
  - cmd_load 80 clears wdt_trip and ramps to 80.
- cmd_load on exactly the expiry cycle (clock 20): wdt_trip stays 0; target = new cmd_vel.
- rst_n pulsed low asynchronously mid-ramp at velocity=-300: velocity=0 and wdt_trip=0 immediately, without waiting for a clk edge.
